// File: rtl/sw_traceback_pkg.sv
// sw_pkg: shared constants and types for the Smith-Waterman traceback engine.
//   - default matrix/read/reference dimensions and score constants
//   - op-code, base, move and FSM state encodings
package sw_pkg;

  localparam int READ_MAX_LENGTH = 128;
  localparam int REF_MAX_LENGTH  = 128;
  localparam int SCORE_W         = 10;
  localparam int MATCH_SCORE     = 2;
  localparam int MISMATCH_SCORE  = -1;
  localparam int GAP_SCORE       = -1;

  typedef enum logic [1:0] {
    OP_MATCH    = 2'd0,
    OP_MISMATCH = 2'd1,
    OP_INS      = 2'd2,
    OP_DEL      = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef enum logic [1:0] {
    MV_DIAG = 2'd0,
    MV_UP   = 2'd1,
    MV_LEFT = 2'd2,
    MV_NONE = 2'd3
  } move_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CUR_RD,
    S_CUR_CAP,
    S_RD_DIAG,
    S_RD_UP,
    S_RD_LEFT,
    S_CAP_LEFT,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/sw_traceback_decide.sv
// sw_tb_decide: combinational predecessor selection for one traceback step.
//   cur/diag/up/left : unsigned stored scores of the current cell and neighbours
//   read_base/ref_base : bases at the current row/column
//   op_code : MATCH/MISMATCH/INS/DEL, move : which neighbour produced cur
//   err : no neighbour is consistent with cur
module sw_tb_decide #(
  parameter int SCORE_W  = sw_pkg::SCORE_W,
  parameter int MATCH    = sw_pkg::MATCH_SCORE,
  parameter int MISMATCH = sw_pkg::MISMATCH_SCORE,
  parameter int GAP      = sw_pkg::GAP_SCORE
) (
  input  logic [SCORE_W-1:0] cur,
  input  logic [SCORE_W-1:0] diag,
  input  logic [SCORE_W-1:0] up,
  input  logic [SCORE_W-1:0] left,
  input  logic [1:0]         read_base,
  input  logic [1:0]         ref_base,
  output logic [1:0]         op_code,
  output logic [1:0]         move,
  output logic               err
);
  import sw_pkg::*;

  // Two extra bits: one for sign, one so score+constant cannot wrap.
  localparam int AW = SCORE_W + 2;

  logic signed [AW-1:0] cur_s, diag_s, up_s, left_s, sub_s, gap_s;
  logic                 same;

  always_comb begin
    same   = (read_base == ref_base);
    cur_s  = $signed({2'b00, cur});
    diag_s = $signed({2'b00, diag});
    up_s   = $signed({2'b00, up});
    left_s = $signed({2'b00, left});
    sub_s  = same ? AW'(MATCH) : AW'(MISMATCH);
    gap_s  = AW'(GAP);

    op_code = OP_MATCH;
    move    = MV_NONE;
    err     = 1'b0;
    if (diag_s + sub_s == cur_s) begin
      op_code = same ? OP_MATCH : OP_MISMATCH;
      move    = MV_DIAG;
    end else if (up_s + gap_s == cur_s) begin
      op_code = OP_INS;
      move    = MV_UP;
    end else if (left_s + gap_s == cur_s) begin
      op_code = OP_DEL;
      move    = MV_LEFT;
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/sw_traceback.sv
// sw_traceback: walks the stored Smith-Waterman score matrix back from the best
// cell and streams alignment ops (end to start) over valid/ready.
//   i_clk/i_rst          : clock, synchronous active-high reset
//   i_start, i_max_i/j   : start pulse and end cell of the alignment
//   i_read_seq/i_ref_seq : packed 2-bit bases, base k at [2(k-1)+:2]
//   o_mat_*/i_mat_score  : matrix read port, data one cycle after address
//   o_op_valid/i_op_ready/o_op_code : op stream
//   o_done, o_beg_i/j, o_len, o_err : walk result, valid with o_done
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_CUR_RD   | address the end cell
// S_CUR_CAP  | capture end-cell score, termination check
// S_RD_DIAG  | address (i-1, j-1)
// S_RD_UP    | address (i-1, j), capture diag
// S_RD_LEFT  | address (i, j-1), capture up
// S_CAP_LEFT | left arrives, pick predecessor
// S_EMIT     | present op until accepted, then advance
// S_DONE     | one-cycle result pulse
module sw_traceback #(
  parameter int READ_MAX_LENGTH = 128,
  parameter int REF_MAX_LENGTH  = 128,
  parameter int SCORE_W         = 10,
  parameter int MATCH           = 2,
  parameter int MISMATCH        = -1,
  parameter int GAP             = -1,
  localparam int IW             = $clog2(READ_MAX_LENGTH) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [IW-1:0]                i_max_i,
  input  logic [IW-1:0]                i_max_j,
  input  logic [2*READ_MAX_LENGTH-1:0] i_read_seq,
  input  logic [2*REF_MAX_LENGTH-1:0]  i_ref_seq,
  output logic                         o_mat_start,
  output logic [IW-1:0]                o_mat_i,
  output logic [IW-1:0]                o_mat_j,
  output logic                         o_mat_op,
  input  logic [SCORE_W-1:0]           i_mat_score,
  output logic                         o_op_valid,
  input  logic                         i_op_ready,
  output logic [1:0]                   o_op_code,
  output logic                         o_done,
  output logic [IW-1:0]                o_beg_i,
  output logic [IW-1:0]                o_beg_j,
  output logic [8:0]                   o_len,
  output logic                         o_err
);
  import sw_pkg::*;

  localparam int RAW = $clog2(READ_MAX_LENGTH);
  localparam int FAW = $clog2(REF_MAX_LENGTH);

  state_t               state, state_n;
  logic [IW-1:0]        cur_i, cur_j, nxt_i, nxt_j, mat_i, mat_j, beg_i, beg_j;
  logic [SCORE_W-1:0]   cur_score, nxt_score, diag_sc, up_sc;
  logic [1:0]           op_reg, dec_op, dec_move;
  logic                 dec_err, mat_start, err_r;
  logic [8:0]           len;
  logic [RAW-1:0]       ri;
  logic [FAW-1:0]       rj;
  logic [1:0]           read_b, ref_b;
  logic                 term_cap, term_emit;

  // Matrix row/column k holds base k, stored at index k-1 of the sequence.
  assign ri     = RAW'(cur_i - IW'(1));
  assign rj     = FAW'(cur_j - IW'(1));
  assign read_b = i_read_seq[{ri, 1'b0} +: 2];
  assign ref_b  = i_ref_seq[{rj, 1'b0} +: 2];

  // The end-cell score is checked as it arrives, before it is registered.
  assign term_cap  = (i_mat_score == '0) || (cur_i == '0) || (cur_j == '0);
  assign term_emit = (nxt_score == '0) || (nxt_i == '0) || (nxt_j == '0);

  sw_tb_decide #(
    .SCORE_W (SCORE_W),
    .MATCH   (MATCH),
    .MISMATCH(MISMATCH),
    .GAP     (GAP)
  ) u_decide (
    .cur      (cur_score),
    .diag     (diag_sc),
    .up       (up_sc),
    .left     (i_mat_score),
    .read_base(read_b),
    .ref_base (ref_b),
    .op_code  (dec_op),
    .move     (dec_move),
    .err      (dec_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (i_start) state_n = S_CUR_RD;
      S_CUR_RD:   state_n = S_CUR_CAP;
      S_CUR_CAP:  state_n = term_cap ? S_DONE : S_RD_DIAG;
      S_RD_DIAG:  state_n = S_RD_UP;
      S_RD_UP:    state_n = S_RD_LEFT;
      S_RD_LEFT:  state_n = S_CAP_LEFT;
      S_CAP_LEFT: state_n = dec_err ? S_DONE : S_EMIT;
      S_EMIT:     if (i_op_ready) state_n = term_emit ? S_DONE : S_RD_DIAG;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_i     <= '0;
      cur_j     <= '0;
      nxt_i     <= '0;
      nxt_j     <= '0;
      cur_score <= '0;
      nxt_score <= '0;
      diag_sc   <= '0;
      up_sc     <= '0;
      op_reg    <= '0;
      mat_i     <= '0;
      mat_j     <= '0;
      mat_start <= 1'b0;
      beg_i     <= '0;
      beg_j     <= '0;
      len       <= '0;
      err_r     <= 1'b0;
    end else begin
      mat_start <= 1'b0;
      // Result cell is latched once, on the way into S_DONE.
      if (state_n == S_DONE && state != S_DONE) begin
        beg_i <= ((state == S_EMIT) ? nxt_i : cur_i) + IW'(1);
        beg_j <= ((state == S_EMIT) ? nxt_j : cur_j) + IW'(1);
      end
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cur_i     <= i_max_i;
            cur_j     <= i_max_j;
            mat_i     <= i_max_i;
            mat_j     <= i_max_j;
            len       <= '0;
            err_r     <= 1'b0;
            mat_start <= 1'b1;
          end
        end
        S_CUR_CAP: begin
          cur_score <= i_mat_score;
          if (!term_cap) begin
            mat_i <= cur_i - IW'(1);
            mat_j <= cur_j - IW'(1);
          end
        end
        S_RD_DIAG: begin
          mat_i <= cur_i - IW'(1);
          mat_j <= cur_j;
        end
        S_RD_UP: begin
          diag_sc <= i_mat_score;
          mat_i   <= cur_i;
          mat_j   <= cur_j - IW'(1);
        end
        S_RD_LEFT: up_sc <= i_mat_score;
        S_CAP_LEFT: begin
          op_reg <= dec_op;
          if (dec_err) err_r <= 1'b1;
          case (dec_move)
            MV_DIAG: begin
              nxt_i     <= cur_i - IW'(1);
              nxt_j     <= cur_j - IW'(1);
              nxt_score <= diag_sc;
            end
            MV_UP: begin
              nxt_i     <= cur_i - IW'(1);
              nxt_j     <= cur_j;
              nxt_score <= up_sc;
            end
            default: begin
              nxt_i     <= cur_i;
              nxt_j     <= cur_j - IW'(1);
              nxt_score <= i_mat_score;
            end
          endcase
        end
        S_EMIT: begin
          if (i_op_ready) begin
            len       <= len + 9'd1;
            cur_i     <= nxt_i;
            cur_j     <= nxt_j;
            cur_score <= nxt_score;
            if (!term_emit) begin
              mat_i <= nxt_i - IW'(1);
              mat_j <= nxt_j - IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mat_start = mat_start;
  assign o_mat_i     = mat_i;
  assign o_mat_j     = mat_j;
  assign o_mat_op    = 1'b0;
  assign o_op_valid  = (state == S_EMIT);
  assign o_op_code   = op_reg;
  assign o_done      = (state == S_DONE);
  assign o_beg_i     = beg_i;
  assign o_beg_j     = beg_j;
  assign o_len       = len;
  assign o_err       = err_r;

endmodule

// File: tb/tb_sw_traceback.sv
// tb_sw_traceback: directed bench for sw_traceback with a small registered
// score-matrix model answering the read port one cycle after each address.
module tb_sw_traceback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   max_i, max_j;
  logic [255:0] read_seq, ref_seq;
  logic         mat_start;
  logic [7:0]   mat_i, mat_j;
  logic         mat_op;
  logic [9:0]   mat_q;
  logic         op_valid, op_ready;
  logic [1:0]   op_code;
  logic         done;
  logic [7:0]   beg_i, beg_j;
  logic [8:0]   len;
  logic         err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [9:0] hmem [16][16];

  int         w_ops [4];
  int         w_nops, w_first, w_done_cyc;
  logic [7:0] w_beg_i, w_beg_j;
  logic [8:0] w_len;
  logic       w_err;

  always #5 clk = ~clk;

  always @(posedge clk) mat_q <= hmem[mat_i[3:0]][mat_j[3:0]];

  sw_traceback dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_max_i    (max_i),
    .i_max_j    (max_j),
    .i_read_seq (read_seq),
    .i_ref_seq  (ref_seq),
    .o_mat_start(mat_start),
    .o_mat_i    (mat_i),
    .o_mat_j    (mat_j),
    .o_mat_op   (mat_op),
    .i_mat_score(mat_q),
    .o_op_valid (op_valid),
    .i_op_ready (op_ready),
    .o_op_code  (op_code),
    .o_done     (done),
    .o_beg_i    (beg_i),
    .o_beg_j    (beg_j),
    .o_len      (len),
    .o_err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        hmem[a][b] = '0;
  endtask

  task automatic set_seq(input logic [1:0] r1, input logic [1:0] r2,
                         input logic [1:0] f1, input logic [1:0] f2);
    read_seq      = '0;
    ref_seq       = '0;
    read_seq[1:0] = r1;
    read_seq[3:2] = r2;
    ref_seq[1:0]  = f1;
    ref_seq[3:2]  = f2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, op_valid}, 0);
    chk({tag, "_code"}, {30'd0, op_code}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_len"}, {23'd0, len}, 0);
    chk({tag, "_beg"}, {16'd0, beg_i, beg_j}, 0);
    chk({tag, "_mat"}, {16'd0, mat_i, mat_j}, 0);
    chk({tag, "_mstart"}, {30'd0, mat_op, mat_start}, 0);
  endtask

  // Cycle 0 is the cycle i_start is high; cycle k is k clock edges later.
  task automatic run_walk(input logic [7:0] mi, input logic [7:0] mj,
                          input int stall, input bit noise);
    int         cyc;
    int         stall_left;
    logic [1:0] held_code;
    logic [15:0] held_mat;
    w_nops = 0; w_first = -1; w_done_cyc = -1;
    w_beg_i = '1; w_beg_j = '1; w_len = '1; w_err = 1'bx;
    for (int k = 0; k < 4; k++) w_ops[k] = 7;
    held_code = '0; held_mat = '0;
    stall_left = stall;
    max_i = mi; max_j = mj; start = 1'b1; op_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("first_addr", {16'd0, mat_i, mat_j}, {16'd0, mi, mj});
    chk("mat_start_pulse", {31'd0, mat_start}, 1);
    while (cyc < 100) begin
      if (noise && cyc == 4) begin
        start = 1'b1; max_i = 8'd9; max_j = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        w_done_cyc = cyc; w_beg_i = beg_i; w_beg_j = beg_j;
        w_len = len; w_err = err;
        break;
      end
      if (op_valid) begin
        if (w_first < 0) w_first = cyc;
        if (stall_left > 0) begin
          op_ready = 1'b0;
          if (cyc == w_first) begin
            held_code = op_code;
            held_mat  = {mat_i, mat_j};
          end else begin
            chk("stall_code_stable", {30'd0, op_code}, {30'd0, held_code});
            chk("stall_no_reads", {16'd0, mat_i, mat_j}, {16'd0, held_mat});
          end
          stall_left--;
        end else begin
          op_ready = 1'b1;
          if (w_nops < 4) w_ops[w_nops] = int'(op_code);
          w_nops++;
        end
      end else begin
        op_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    op_ready = 1'b1;
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
  endtask

  task automatic expect_walk(input string tag, input int nops, input int op0, input int op1,
                             input int first, input int done_cyc, input int elen,
                             input int bi, input int bj, input int eerr);
    chk({tag, "_nops"}, nops, w_nops);
    chk({tag, "_op0"}, w_ops[0], op0);
    chk({tag, "_op1"}, w_ops[1], op1);
    chk({tag, "_first_valid"}, w_first, first);
    chk({tag, "_done_cycle"}, w_done_cyc, done_cyc);
    chk({tag, "_len"}, {23'd0, w_len}, elen);
    chk({tag, "_beg_i"}, {24'd0, w_beg_i}, bi);
    chk({tag, "_beg_j"}, {24'd0, w_beg_j}, bj);
    chk({tag, "_err"}, {31'd0, w_err}, eerr);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; max_i = '0; max_j = '0; op_ready = 1'b1;
    read_seq = '0; ref_seq = '0;
    clear_mem();
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Read AC / ref AC, two matches.
    set_seq(2'd0, 2'd1, 2'd0, 2'd1);
    clear_mem(); hmem[1][1] = 10'd2; hmem[2][2] = 10'd4;
    run_walk(8'd2, 8'd2, 0, 1'b0);
    expect_walk("match2", 2, 0, 0, 7, 13, 2, 1, 1, 0);

    // Read AG / ref AC, mismatch then match; stray start mid-walk is ignored.
    set_seq(2'd0, 2'd2, 2'd0, 2'd1);
    clear_mem(); hmem[1][1] = 10'd2; hmem[2][2] = 10'd1;
    run_walk(8'd2, 8'd2, 0, 1'b1);
    expect_walk("mismatch", 2, 1, 0, 7, 13, 2, 1, 1, 0);

    // Up gap: (2,1)=1 from (1,1)=2.
    set_seq(2'd0, 2'd1, 2'd0, 2'd1);
    clear_mem(); hmem[1][1] = 10'd2; hmem[2][1] = 10'd1;
    run_walk(8'd2, 8'd1, 0, 1'b0);
    expect_walk("ins", 2, 2, 0, 7, 13, 2, 1, 1, 0);

    // Left gap: (1,2)=1 from (1,1)=2.
    clear_mem(); hmem[1][1] = 10'd2; hmem[1][2] = 10'd1;
    run_walk(8'd1, 8'd2, 0, 1'b0);
    expect_walk("del", 2, 3, 0, 7, 13, 2, 1, 1, 0);

    // Backpressure: three stalled cycles on the first op.
    clear_mem(); hmem[1][1] = 10'd2; hmem[2][2] = 10'd4;
    run_walk(8'd2, 8'd2, 3, 1'b0);
    expect_walk("stall", 2, 0, 0, 7, 16, 2, 1, 1, 0);

    // Start cell scored zero: empty walk.
    clear_mem();
    run_walk(8'd2, 8'd2, 0, 1'b0);
    expect_walk("empty", 0, 7, 7, -1, 3, 0, 3, 3, 0);

    // No consistent predecessor.
    clear_mem(); hmem[2][2] = 10'd5;
    run_walk(8'd2, 8'd2, 0, 1'b0);
    expect_walk("inconsistent", 0, 7, 7, -1, 7, 0, 3, 3, 1);

    // Reset while an op is pending.
    set_seq(2'd0, 2'd2, 2'd0, 2'd1);
    clear_mem(); hmem[1][1] = 10'd2; hmem[2][2] = 10'd1;
    max_i = 8'd2; max_j = 8'd2; start = 1'b1; op_ready = 1'b0;
    tick();
    start = 1'b0;
    guard = 0;
    while (!op_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("rst_reached_emit", {31'd0, op_valid}, 1);
    chk("rst_pending_code", {30'd0, op_code}, 1);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    op_ready = 1'b1;
    tick();
    chk("midrst_no_done", {31'd0, done}, 0);
    run_walk(8'd2, 8'd2, 0, 1'b0);
    expect_walk("after_rst", 2, 1, 0, 7, 13, 2, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sw_traceback.md
# sw_traceback

Smith-Waterman traceback engine. It is the read-side client of the DP score-matrix storage block. Given the end cell of the best local alignment, it walks the stored score matrix backwards, re-derives which predecessor produced each cell, and streams alignment operations (end to start) over a valid/ready interface. It sits after the DP fill stage and before the result formatter.

## Interface
Parameters:
- READ_MAX_LENGTH, 128, max read length; index width IW = $clog2(READ_MAX_LENGTH)+1 = 8
- REF_MAX_LENGTH, 128, max reference length; same index width rule
- SCORE_W, 10, stored score width (unsigned)
- MATCH, 2, diagonal score for equal bases
- MISMATCH, -1, diagonal score for unequal bases
- GAP, -1, linear gap score

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse; accepted only in S_IDLE
- i_max_i  in  IW  row of the end cell (1..READ_MAX_LENGTH)
- i_max_j  in  IW  column of the end cell
- i_read_seq  in  2*READ_MAX_LENGTH  packed read; base k (1-indexed) at [2(k-1)+:2]; A=0, C=1, G=2, T=3
- i_ref_seq  in  2*REF_MAX_LENGTH  packed reference; same packing
- o_mat_start  out  1  one-cycle pulse on start acceptance; wakes the matrix block
- o_mat_i / o_mat_j  out  IW  matrix address
- o_mat_op  out  1  constant 0 (read)
- i_mat_score  in  SCORE_W  matrix data; valid one cycle after its address
- o_op_valid  out  1  operation available
- i_op_ready  in  1  consumer accepts the operation
- o_op_code  out  2  0=MATCH, 1=MISMATCH, 2=INS (up, consumes read), 3=DEL (left, consumes ref)
- o_done  out  1  one-cycle pulse when the walk ends
- o_beg_i / o_beg_j  out  IW  first cell of the alignment; valid with o_done
- o_len  out  9  number of ops emitted; valid with o_done
- o_err  out  1  no predecessor was consistent; valid with o_done

## Operation
- State machine: S_IDLE → S_CUR_RD → S_CUR_CAP → {S_RD_DIAG → S_RD_UP → S_RD_LEFT → S_CAP_LEFT → S_EMIT}* → S_DONE → S_IDLE.
- On start acceptance, latch i_max_i/j into cur_i/cur_j, clear the length counter, and pulse o_mat_start.
- S_CUR_RD: address (cur_i, cur_j). S_CUR_CAP: latch cur_score.
- Termination check (on entry to each step): if cur_score==0, or cur_i==0, or cur_j==0, go to S_DONE.
- Reads per step:
  - S_RD_DIAG addresses (i-1, j-1).
  - S_RD_UP addresses (i-1, j) and captures diag.
  - S_RD_LEFT addresses (i, j-1) and captures up.
  - S_CAP_LEFT captures left and makes the decision.
- Decision arithmetic: signed, SCORE_W+2 bits, operands zero-extended. Priority is diag > up > left.
  - If diag+s(read[i], ref[j]) == cur: op MATCH/MISMATCH, move to (i-1, j-1).
  - Else if up+GAP == cur: op INS, move to (i-1, j).
  - Else if left+GAP == cur: op DEL, move to (i, j-1).
  - Else: set err and go to S_DONE with no op.
- The new cur_score is the matching predecessor value; it is not re-read.
- S_EMIT: o_op_valid=1. o_op_code is held stable until i_op_ready. On the handshake cycle, increment len, update cur_i/j, and run the termination check.
- S_DONE: o_done=1, o_beg_i = cur_i+1, o_beg_j = cur_j+1, o_len, o_err. Then return to S_IDLE.
- Start cell with score 0: no ops, o_len=0, o_beg = (i_max_i+1, i_max_j+1).
- i_start outside S_IDLE is ignored.
- Reset mid-walk: next cycle is S_IDLE, all outputs at reset values, no partial o_done.

## Timing
- Reset values: o_op_valid=0, o_op_code=0, o_done=0, o_err=0, o_len=0, o_beg_i/j=0, o_mat_i/j=0, o_mat_start=0, o_mat_op=0.
- All outputs are registered or decoded from state only; there are no combinational paths from i_op_ready to outputs.
- Start to first matrix address: 1 cycle. Start to first o_op_valid: 7 cycles.
- One step with i_op_ready held high takes 5 cycles: 3 reads, capture, emit.
- o_done asserts 1 cycle after the final handshake, or 3 cycles after start when the walk is empty.
- o_mat_i/j hold their last address when not reading.

## Structure
- Package sw_pkg: READ_MAX_LENGTH, REF_MAX_LENGTH, SCORE_W, score constants, the op-code enum, the base encoding, and the state enum.
- Sub-module sw_tb_decide (combinational): inputs cur, diag, up, left and the two bases; outputs op_code, move, err. It is unit-tested separately.

## Test plan
- Read "AC", ref "AC", H(1,1)=2, H(2,2)=4, start (2,2), ready high → MATCH, MATCH; done with beg (1,1), len 2, err 0; first valid at cycle 7.
- Read "AG", ref "AC", H(1,1)=2, H(2,2)=1, start (2,2) → MISMATCH, MATCH; len 2.
- Gap case, H(1,1)=2, H(2,1)=1, start (2,1) → INS, MATCH; beg (1,1).
- Backpressure: ready low for 3 cycles during the first op → valid and code stable, no extra matrix reads, same op sequence.
- Start cell score 0 → o_done at cycle 3, len 0, no o_op_valid. Inconsistent matrix (cur 5, all neighbours 0) → done with err 1, len 0.
- i_rst asserted during S_EMIT → all outputs zero the next cycle; a new i_start then runs a full correct walk.
